// File: rtl/updown_cnt_sched.sv
// Shared modulo-2^CNT_W up/down counter with a round-robin burst scheduler.
// One requester at a time owns the counter for a burst of len steps.
module updown_cnt_sched #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 2,
    parameter int LEN_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         dir,
    input  logic [N_REQ*LEN_W-1:0]   len,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         cnt,
    output logic                     term
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [LEN_W-1:0] rem;
    logic             dir_q;
    logic [PTR_W-1:0] rr_ptr;

    logic             win_vld;
    logic [PTR_W-1:0] win_idx;
    logic             win_dir;
    logic [LEN_W-1:0] win_len;
    logic [LEN_W-1:0] rem_load;
    logic [N_REQ-1:0] win_oh;
    logic [PTR_W-1:0] ptr_nxt;

    // Search starts at rr_ptr and wraps; the first set request wins.
    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        win_dir = 1'b0;
        win_len = '0;
        idx     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx  = (32'(rr_ptr) + i) % N_REQ;
            cand = PTR_W'(idx);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
                win_dir = dir[cand];
                win_len = len[idx*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
        rem_load        = (win_len == '0) ? LEN_W'(1) : win_len;
        ptr_nxt         = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            gnt    <= '0;
            rem    <= '0;
            dir_q  <= 1'b0;
            rr_ptr <= '0;
        end else if (clr) begin
            // Abort: rr_ptr keeps its value so fairness survives the clear.
            state <= ST_IDLE;
            cnt   <= '0;
            gnt   <= '0;
            rem   <= '0;
        end else if (state == ST_IDLE) begin
            if (win_vld) begin
                state  <= ST_RUN;
                gnt    <= win_oh;
                dir_q  <= win_dir;
                rem    <= rem_load;
                rr_ptr <= ptr_nxt;
            end
        end else begin
            cnt <= dir_q ? cnt - CNT_W'(1) : cnt + CNT_W'(1);
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
                state <= ST_IDLE;
                gnt   <= '0;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_RUN) && (rem == LEN_W'(1));
    assign term = &cnt;

endmodule

// File: tb/tb_updown_cnt_sched.sv
// Self-checking bench for updown_cnt_sched: directed scenarios plus a
// randomized burst-level reference model.
module tb_updown_cnt_sched;

    localparam int N_REQ = 4;
    localparam int CNT_W = 2;
    localparam int LEN_W = 3;
    localparam int MODV  = 1 << CNT_W;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   clr;
    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       dir;
    logic [N_REQ*LEN_W-1:0] len;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   done;
    logic [CNT_W-1:0]       cnt;
    logic                   term;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;
    int m_ptr    = 0;

    updown_cnt_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .dir(dir), .len(len),
        .gnt(gnt), .busy(busy), .done(done), .cnt(cnt), .term(term)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrapc(input int v);
        return ((v % MODV) + MODV) % MODV;
    endfunction

    function automatic int winner(input logic [N_REQ-1:0] m, input int p);
        for (int i = 0; i < N_REQ; i++)
            if (m[(p + i) % N_REQ]) return (p + i) % N_REQ;
        return -1;
    endfunction

    // Expected vector layout: {gnt, busy, done, term, cnt}
    function automatic logic [8:0] mk(input int k, input logic b, input logic d, input int c);
        logic [3:0] oh;
        oh = (k < 0) ? 4'b0000 : (4'b0001 << k);
        return {oh, b, d, (c == MODV - 1), CNT_W'(c)};
    endfunction

    task automatic test_reset();
        logic [8:0] exp_v;
        rst_n = 1'b0; clr = 1'b0; req = '0; dir = '0; len = '0;
        #11;
        exp_v = mk(-1, 0, 0, 0);
        n_checks++;
        if ({gnt, busy, done, term, cnt} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", {gnt, busy, done, term, cnt}, exp_v);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({gnt, busy, done, term, cnt} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got %h expected %h", i, {gnt, busy, done, term, cnt}, exp_v);
            end
        end
        m_cnt = 0; m_ptr = 0;
    endtask

    task automatic test_up_wrap();
        logic [8:0] exp_v;
        req = 4'b0001; dir = '0; len = '0; len[2:0] = 3'd5;
        for (int j = 1; j <= 5; j++) begin
            step();
            exp_v = mk(0, 1, (j == 5), wrapc(j - 1));
            n_checks++;
            if ({gnt, busy, done, term, cnt} !== exp_v) begin
                n_fail++;
                $display("FAIL up_wrap[%0d]: got %h expected %h", j, {gnt, busy, done, term, cnt}, exp_v);
            end
            if (j == 5) req = '0;
        end
        step();
        exp_v = mk(-1, 0, 0, 1);
        n_checks++;
        if ({gnt, busy, done, term, cnt} !== exp_v) begin
            n_fail++;
            $display("FAIL up_wrap_end: got %h expected %h", {gnt, busy, done, term, cnt}, exp_v);
        end
        m_cnt = 1; m_ptr = 1;
    endtask

    task automatic test_round_robin();
        logic [8:0] exp_v;
        rst_n = 1'b0; #3; rst_n = 1'b1;
        req = 4'b1111; dir = '0; len = {4{3'd1}};
        for (int i = 0; i < 5; i++) begin
            step();
            exp_v = mk(i % N_REQ, 1, 1, wrapc(i));
            n_checks++;
            if ({gnt, busy, done, term, cnt} !== exp_v) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %h expected %h", i, {gnt, busy, done, term, cnt}, exp_v);
            end
            if (i == 4) req = '0;
            step();
            exp_v = mk(-1, 0, 0, wrapc(i + 1));
            n_checks++;
            if ({gnt, busy, done, term, cnt} !== exp_v) begin
                n_fail++;
                $display("FAIL rr_idle[%0d]: got %h expected %h", i, {gnt, busy, done, term, cnt}, exp_v);
            end
        end
        m_cnt = 1; m_ptr = 1;
    endtask

    task automatic test_down_len0();
        logic [8:0] exp_v;
        clr = 1'b1;
        step();
        clr = 1'b0;
        exp_v = mk(-1, 0, 0, 0);
        n_checks++;
        if ({gnt, busy, done, term, cnt} !== exp_v) begin
            n_fail++;
            $display("FAIL down_clr: got %h expected %h", {gnt, busy, done, term, cnt}, exp_v);
        end
        req = 4'b0100; dir = 4'b0100; len = '0;
        step();
        exp_v = mk(2, 1, 1, 0);
        n_checks++;
        if ({gnt, busy, done, term, cnt} !== exp_v) begin
            n_fail++;
            $display("FAIL down_grant: got %h expected %h", {gnt, busy, done, term, cnt}, exp_v);
        end
        req = '0;
        step();
        exp_v = mk(-1, 0, 0, 3);
        n_checks++;
        if ({gnt, busy, done, term, cnt} !== exp_v) begin
            n_fail++;
            $display("FAIL down_end: got %h expected %h", {gnt, busy, done, term, cnt}, exp_v);
        end
        m_cnt = 3; m_ptr = 3;
    endtask

    task automatic test_clr_mid();
        logic [8:0] exp_v;
        req = 4'b0010; dir = '0; len = '0; len[5:3] = 3'd6;
        for (int j = 1; j <= 3; j++) begin
            step();
            exp_v = mk(1, 1, 0, wrapc(m_cnt + j - 1));
            n_checks++;
            if ({gnt, busy, done, term, cnt} !== exp_v) begin
                n_fail++;
                $display("FAIL clr_run[%0d]: got %h expected %h", j, {gnt, busy, done, term, cnt}, exp_v);
            end
        end
        clr = 1'b1; req = 4'b1001; len[11:9] = 3'd1;
        for (int j = 0; j < 2; j++) begin
            step();
            exp_v = mk(-1, 0, 0, 0);
            n_checks++;
            if ({gnt, busy, done, term, cnt} !== exp_v) begin
                n_fail++;
                $display("FAIL clr_abort[%0d]: got %h expected %h", j, {gnt, busy, done, term, cnt}, exp_v);
            end
        end
        clr = 1'b0;
        step();
        exp_v = mk(3, 1, 1, 0);
        n_checks++;
        if ({gnt, busy, done, term, cnt} !== exp_v) begin
            n_fail++;
            $display("FAIL clr_next_grant: got %h expected %h", {gnt, busy, done, term, cnt}, exp_v);
        end
        req = '0;
        step();
        exp_v = mk(-1, 0, 0, 1);
        n_checks++;
        if ({gnt, busy, done, term, cnt} !== exp_v) begin
            n_fail++;
            $display("FAIL clr_next_end: got %h expected %h", {gnt, busy, done, term, cnt}, exp_v);
        end
        m_cnt = 1; m_ptr = 0;
    endtask

    task automatic test_async_reset();
        logic [8:0] exp_v;
        req = 4'b0100; dir = '0; len = '0; len[8:6] = 3'd7;
        for (int j = 1; j <= 2; j++) begin
            step();
            exp_v = mk(2, 1, 0, wrapc(m_cnt + j - 1));
            n_checks++;
            if ({gnt, busy, done, term, cnt} !== exp_v) begin
                n_fail++;
                $display("FAIL arst_run[%0d]: got %h expected %h", j, {gnt, busy, done, term, cnt}, exp_v);
            end
        end
        #3 rst_n = 1'b0;
        #1;
        exp_v = mk(-1, 0, 0, 0);
        n_checks++;
        if ({gnt, busy, done, term, cnt} !== exp_v) begin
            n_fail++;
            $display("FAIL arst_immediate: got %h expected %h", {gnt, busy, done, term, cnt}, exp_v);
        end
        #1 rst_n = 1'b1;
        req = 4'b1111; len = {4{3'd1}}; dir = '0;
        step();
        exp_v = mk(0, 1, 1, 0);
        n_checks++;
        if ({gnt, busy, done, term, cnt} !== exp_v) begin
            n_fail++;
            $display("FAIL arst_first_prio: got %h expected %h", {gnt, busy, done, term, cnt}, exp_v);
        end
        req = '0;
        step();
        exp_v = mk(-1, 0, 0, 1);
        n_checks++;
        if ({gnt, busy, done, term, cnt} !== exp_v) begin
            n_fail++;
            $display("FAIL arst_end: got %h expected %h", {gnt, busy, done, term, cnt}, exp_v);
        end
        m_cnt = 1; m_ptr = 1;
    endtask

    // Burst-level model: winner by rotating search, count moves L steps of +/-1.
    task automatic test_random();
        logic [8:0] exp_v;
        int k, L, s;
        for (int it = 0; it < 80; it++) begin
            req = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            dir = 4'($urandom_range(0, 15));
            len = 12'($urandom_range(0, 4095));
            k = winner(req, m_ptr);
            if (k < 0) begin
                step();
                exp_v = mk(-1, 0, 0, m_cnt);
                n_checks++;
                if ({gnt, busy, done, term, cnt} !== exp_v) begin
                    n_fail++;
                    $display("FAIL rand_nogrant[%0d]: got %h expected %h", it, {gnt, busy, done, term, cnt}, exp_v);
                end
                continue;
            end
            L = int'(len[k*LEN_W +: LEN_W]);
            if (L == 0) L = 1;
            s = dir[k] ? -1 : 1;
            for (int j = 1; j <= L; j++) begin
                step();
                exp_v = mk(k, 1, (j == L), wrapc(m_cnt + (j - 1) * s));
                n_checks++;
                if ({gnt, busy, done, term, cnt} !== exp_v) begin
                    n_fail++;
                    $display("FAIL rand_run[%0d.%0d]: got %h expected %h", it, j, {gnt, busy, done, term, cnt}, exp_v);
                end
                req = 4'($urandom_range(0, 15));
                dir = 4'($urandom_range(0, 15));
                len = 12'($urandom_range(0, 4095));
            end
            m_cnt = wrapc(m_cnt + L * s);
            m_ptr = (k + 1) % N_REQ;
            step();
            exp_v = mk(-1, 0, 0, m_cnt);
            n_checks++;
            if ({gnt, busy, done, term, cnt} !== exp_v) begin
                n_fail++;
                $display("FAIL rand_end[%0d]: got %h expected %h", it, {gnt, busy, done, term, cnt}, exp_v);
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_round_robin();
        test_down_len0();
        test_clr_mid();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
